fft_input_loader: RTL and testbench

//  Input stage that sits directly upstream of the 64x(2*WIDTH) dual-port FFT working RAM.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_bitrev.sv | 13 +
 rtl/fft_input_loader.sv | 132 +++++++++++++
 tb/tb_fft_input_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front-end blocks: default sizes, loader state
// encoding and a generic bit-reversal helper.
package fft_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LOG2N_DEF = 6;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Reverses the low n bits of idx (n <= 16); upper result bits are zero.
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) r[4'(i)] = idx[4'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Combinational N-bit index reversal; shared by the FFT loader and unloader.
module fft_bitrev #(
  parameter int N = 6
) (
  input  logic [N-1:0] idx,
  output logic [N-1:0] rev
);

  for (genvar i = 0; i < N; i++) begin : g_rev
    assign rev[i] = idx[N-1-i];
  end

endmodule

// File: rtl/fft_input_loader.sv
// Packs real sample pairs into complex words and writes them bit-reversed into
// the FFT working RAM, then hands the full frame to the FFT engine.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_FILL | accepting samples, one RAM write per even/odd pair
//   ST_HOLD | frame resident in RAM; input stalled until Fft_Ack
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [WIDTH-1:0]   In_Data,
  input  logic               In_Last,
  output logic               Ram_We,
  output logic [LOG2N-1:0]   Ram_Addr,
  output logic [2*WIDTH-1:0] Ram_DI,
  output logic               Frame_Rdy,
  input  logic               Fft_Ack,
  output logic               Err
);

  localparam logic [LOG2N:0] CNT_LAST = '1;

  state_e               state_q, state_d;
  logic [LOG2N:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     hold_q, hold_d;
  logic                 ready_q, ready_d;
  logic                 we_q, we_d;
  logic [LOG2N-1:0]     addr_q, addr_d;
  logic [2*WIDTH-1:0]   di_q, di_d;
  logic                 frame_rdy_q, frame_rdy_d;
  logic                 err_q, err_d;

  logic [LOG2N-1:0]     pair_rev;
  logic                 accept;
  logic                 is_final;

  fft_bitrev #(.N(LOG2N)) u_bitrev (
    .idx (cnt_q[LOG2N:1]),
    .rev (pair_rev)
  );

  assign accept   = In_Valid & ready_q;
  assign is_final = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    di_d        = di_q;
    frame_rdy_d = frame_rdy_q;
    err_d       = err_q;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (In_Last && !is_final) begin
            // Early In_Last: drop the partial frame and restart at sample 0.
            err_d  = 1'b1;
            cnt_d  = '0;
            hold_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (!cnt_q[0]) begin
              hold_d = In_Data;
            end else begin
              we_d   = 1'b1;
              addr_d = pair_rev;
              di_d   = {hold_q, In_Data};
            end
            if (is_final) begin
              state_d = ST_HOLD;
              if (!In_Last) err_d = 1'b1;
            end
          end
        end
      end
      ST_HOLD: begin
        // Frame_Rdy waits until the final write has been presented to the RAM.
        if (we_q) frame_rdy_d = 1'b1;
        if (Fft_Ack) begin
          state_d     = ST_FILL;
          frame_rdy_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase

    ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      hold_q      <= '0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      di_q        <= '0;
      frame_rdy_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
      frame_rdy_q <= frame_rdy_d;
      err_q       <= err_d;
    end
  end

  assign In_Ready  = ready_q;
  assign Ram_We    = we_q;
  assign Ram_Addr  = addr_q;
  assign Ram_DI    = di_q;
  assign Frame_Rdy = frame_rdy_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: behavioural RAM capture, vector table for
// selected RAM words, hand-written sequences for handshake, framing and reset.
module tb_fft_input_loader;

  logic        Clk;
  logic        Rst_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] In_Data;
  logic        In_Last;
  logic        Ram_We;
  logic [5:0]  Ram_Addr;
  logic [63:0] Ram_DI;
  logic        Frame_Rdy;
  logic        Fft_Ack;
  logic        Err;

  fft_input_loader #(.WIDTH(32), .LOG2N(6)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .In_Last   (In_Last),
    .Ram_We    (Ram_We),
    .Ram_Addr  (Ram_Addr),
    .Ram_DI    (Ram_DI),
    .Frame_Rdy (Frame_Rdy),
    .Fft_Ack   (Fft_Ack),
    .Err       (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM model: captures writes on the falling edge; the initial block requests
  // a clear by bumping clr_gen so only this process writes the image.
  logic [63:0] ram_img [64];
  int          wr_cnt = 0;
  int          clr_gen = 0;
  int          clr_seen = 0;
  logic [5:0]  first_addr;
  logic [63:0] first_di;

  always @(negedge Clk) begin
    if (clr_gen != clr_seen) begin
      for (int i = 0; i < 64; i++) ram_img[i] = '1;
      wr_cnt   = 0;
      clr_seen = clr_gen;
    end
    if (Ram_We === 1'b1) begin
      if (wr_cnt == 0) begin
        first_addr = Ram_Addr;
        first_di   = Ram_DI;
      end
      ram_img[Ram_Addr] = Ram_DI;
      wr_cnt++;
    end
  end

  typedef struct {
    int          k;
    logic [5:0]  addr;
    logic [31:0] re;
    logic [31:0] im;
  } vec_t;

  vec_t vecs [8];

  function automatic int tb_rev(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r = (r << 1) | (x & 1);
      x = x >> 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_img();
    clr_gen++;
    @(negedge Clk);
    #1;
  endtask

  task automatic send(input logic [31:0] data, input logic last);
    int n;
    In_Valid = 1'b1;
    In_Data  = data;
    In_Last  = last;
    n = 0;
    while (In_Ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: In_Ready stuck low for sample %0d", data);
    end else begin
      tick();
    end
    In_Valid = 1'b0;
    In_Last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(1) == 1) tick();
      send(32'(i), i == last_at);
    end
  endtask

  task automatic check_frame(input string name);
    int errs;
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      if (ram_img[tb_rev(k)] !== {32'(2 * k), 32'(2 * k + 1)}) errs++;
    end
    check({name, "_img_errs"}, 64'(errs), 64'd0);
    check({name, "_wr_cnt"}, 64'(wr_cnt), 64'd64);
  endtask

  task automatic ack();
    Fft_Ack = 1'b1;
    tick();
    Fft_Ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    vecs[0] = '{k: 0,  addr: 6'd0,  re: 32'd0,   im: 32'd1};
    vecs[1] = '{k: 1,  addr: 6'd32, re: 32'd2,   im: 32'd3};
    vecs[2] = '{k: 2,  addr: 6'd16, re: 32'd4,   im: 32'd5};
    vecs[3] = '{k: 3,  addr: 6'd48, re: 32'd6,   im: 32'd7};
    vecs[4] = '{k: 5,  addr: 6'd40, re: 32'd10,  im: 32'd11};
    vecs[5] = '{k: 10, addr: 6'd20, re: 32'd20,  im: 32'd21};
    vecs[6] = '{k: 32, addr: 6'd1,  re: 32'd64,  im: 32'd65};
    vecs[7] = '{k: 63, addr: 6'd63, re: 32'd126, im: 32'd127};

    Rst_n    = 1'b0;
    In_Valid = 1'b0;
    In_Data  = '0;
    In_Last  = 1'b0;
    Fft_Ack  = 1'b0;
    repeat (3) tick();

    check("rst_in_ready", 64'(In_Ready), 64'd0);
    check("rst_flags", {61'd0, Ram_We, Frame_Rdy, Err}, 64'd0);
    check("rst_addr", 64'(Ram_Addr), 64'd0);
    check("rst_di", Ram_DI, 64'd0);

    Rst_n = 1'b1;
    tick();
    check("ready_after_rst", 64'(In_Ready), 64'd1);

    // Scenario 1: back-to-back full frame
    clear_img();
    send_frame(128, 127, 1'b0);
    check("s1_last_we", 64'(Ram_We), 64'd1);
    check("s1_last_addr", 64'(Ram_Addr), 64'd63);
    check("s1_last_di", Ram_DI, {32'd126, 32'd127});
    check("s1_ready_hold", 64'(In_Ready), 64'd0);
    check("s1_frdy_early", 64'(Frame_Rdy), 64'd0);
    tick();
    check("s1_we_pulse", 64'(Ram_We), 64'd0);
    check("s1_frdy", 64'(Frame_Rdy), 64'd1);
    check("s1_err", 64'(Err), 64'd0);
    check_frame("s1");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("vec_k%0d", vecs[i].k), ram_img[vecs[i].addr], {vecs[i].re, vecs[i].im});
    end

    // Scenario 2: input held off in HOLD, then released by Fft_Ack
    In_Valid = 1'b1;
    In_Data  = 32'hdead;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (In_Ready !== 1'b0 || Ram_We !== 1'b0) bad++;
    end
    In_Valid = 1'b0;
    check("s2_hold_stall", 64'(bad), 64'd0);
    check("s2_no_writes", 64'(wr_cnt), 64'd64);
    check("s2_frdy_held", 64'(Frame_Rdy), 64'd1);
    ack();
    check("s2_ready_after_ack", 64'(In_Ready), 64'd1);
    check("s2_frdy_cleared", 64'(Frame_Rdy), 64'd0);

    // Scenario 3: early In_Last on sample 9 discards the partial frame
    clear_img();
    send_frame(10, 9, 1'b0);
    check("s3_err", 64'(Err), 64'd1);
    tick();
    tick();
    check("s3_partial_writes", 64'(wr_cnt), 64'd4);
    check("s3_still_fill", 64'(In_Ready), 64'd1);
    clear_img();
    send_frame(128, 127, 1'b0);
    tick();
    check("s3_first_addr", 64'(first_addr), 64'd0);
    check("s3_first_di", first_di, {32'd0, 32'd1});
    check_frame("s3");
    check("s3_frdy", 64'(Frame_Rdy), 64'd1);
    check("s3_err_sticky", 64'(Err), 64'd1);
    ack();

    // Scenario 6: one-cycle reset after sample 70
    clear_img();
    send_frame(71, -1, 1'b0);
    Rst_n = 1'b0;
    tick();
    check("s6_in_ready", 64'(In_Ready), 64'd0);
    check("s6_flags", {61'd0, Ram_We, Frame_Rdy, Err}, 64'd0);
    check("s6_addr", 64'(Ram_Addr), 64'd0);
    check("s6_di", Ram_DI, 64'd0);
    Rst_n = 1'b1;

    // Scenario 5: fresh frame with random valid gaps
    clear_img();
    send_frame(128, 127, 1'b1);
    tick();
    check_frame("s5");
    check("s5_frdy", 64'(Frame_Rdy), 64'd1);
    check("s5_err", 64'(Err), 64'd0);
    ack();

    // Scenario 4: final sample without In_Last
    clear_img();
    send_frame(128, -1, 1'b0);
    tick();
    check_frame("s4");
    check("s4_frdy", 64'(Frame_Rdy), 64'd1);
    check("s4_err", 64'(Err), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
